// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory model: word width, word type and
// the four-state RAM handshake status.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_model_if.sv
// RAM request/response bus between a CPU-side master and the RAM model.
// The master holds ramREN/ramWEN, ramaddr and ramstore steady until it
// sees ramstate==ACCESS; the RAM answers with ramstate and ramload.
interface ram_model_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate
  );

endinterface

// File: rtl/ram_model.sv
// Word-addressed RAM model with LAT wait states before a one-cycle ACCESS.
// A request is valid when exactly one of ramREN/ramWEN is high and the byte
// address is word aligned and inside the array; anything else with a request
// present parks the FSM in ERROR. Requests are latched when an access starts,
// a change while waiting restarts the wait, and a write is committed only on
// the closing edge of ACCESS if the master is still asserting the same write.
// LAT must lie in 0..15 and WORDS must be a power of two.
// Optional feature: define RAM_STATS_EN to add rdcount/wrcount outputs that
// count completed read and committed write ACCESS cycles.
module ram_model
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int WORDS = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  ram_model_if.slave bus
`ifdef RAM_STATS_EN
  ,
  output word_t      rdcount,
  output word_t      wrcount
`endif
);

  localparam int WORDS_W = $clog2(WORDS);

  ramstate_t          r_state;
  logic [3:0]         r_count;
  logic               r_ren;
  logic               r_wen;
  word_t              r_addr;
  word_t              r_store;
  word_t              r_mem [WORDS];

  logic               w_any;
  logic               w_valid;
  logic               w_err;
  logic               w_same;
  logic               w_commit;
  logic               w_latch;
  ramstate_t          w_nextState;
  logic [3:0]         w_nextCount;
  logic [WORDS_W-1:0] w_index;

  // Request classification against the live bus and the latched request
  assign w_any    = bus.ramREN | bus.ramWEN;
  assign w_valid  = (bus.ramREN ^ bus.ramWEN) &&
                    (bus.ramaddr[1:0] == 2'b00) &&
                    ({2'b00, bus.ramaddr[WORD_W-1:2]} < word_t'(WORDS));
  assign w_err    = w_any && !w_valid;
  assign w_same   = (bus.ramREN == r_ren) && (bus.ramWEN == r_wen) &&
                    (bus.ramaddr == r_addr) && (bus.ramstore == r_store);
  assign w_index  = r_addr[WORDS_W+1:2];
  assign w_commit = (r_state == ACCESS) && r_wen && bus.ramWEN && w_same && !RST;

  // Next-state logic: errors win from any state, BUSY counts down, and
  // FREE/ACCESS/ERROR all re-evaluate the bus as a fresh request
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_latch     = 1'b0;
    if (w_err) begin
      w_nextState = ERROR;
      w_nextCount = 4'd0;
    end else begin
      case (r_state)
        BUSY: begin
          if (!w_any) begin
            w_nextState = FREE;
            w_nextCount = 4'd0;
          end else if (!w_same) begin
            w_latch     = 1'b1;
            w_nextCount = 4'(LAT);
          end else if (r_count == 4'd1) begin
            w_nextState = ACCESS;
            w_nextCount = 4'd0;
          end else begin
            w_nextCount = r_count - 4'd1;
          end
        end
        default: begin
          if (w_valid) begin
            w_latch = 1'b1;
            if (LAT == 0) begin
              w_nextState = ACCESS;
              w_nextCount = 4'd0;
            end else begin
              w_nextState = BUSY;
              w_nextCount = 4'(LAT);
            end
          end else begin
            w_nextState = FREE;
            w_nextCount = 4'd0;
          end
        end
      endcase
    end
  end

  // State, wait counter and latched request registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FREE;
      r_count <= 4'd0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_latch) begin
        r_ren   <= bus.ramREN;
        r_wen   <= bus.ramWEN;
        r_addr  <= bus.ramaddr;
        r_store <= bus.ramstore;
      end
    end
  end

  // Memory array write port; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (w_commit) begin
      r_mem[w_index] <= r_store;
    end
  end

  assign bus.ramstate = r_state;
  assign bus.ramload  = (r_state == ACCESS && r_ren) ? r_mem[w_index] : '0;

`ifdef RAM_STATS_EN
  // Completed-read and committed-write counters, free-running with wrap
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdcount <= '0;
      wrcount <= '0;
    end else begin
      if (r_state == ACCESS && r_ren) begin
        rdcount <= rdcount + 32'd1;
      end
      if (w_commit) begin
        wrcount <= wrcount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_model.sv
// Bench for ram_model: three instances (LAT=0, 2, 3) share one clock and
// reset. Read data expected from the bench is queued when a read is driven
// and popped when that instance is due to show ACCESS.
// Optional feature: RAM_STATS_EN also checks rdcount/wrcount after reset.
module tb_ram_model;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  int    nCompared   = 0;
  int    nMismatched = 0;
  word_t expQ [$];

  ram_model_if bus0 ();
  ram_model_if bus2 ();
  ram_model_if bus3 ();

`ifdef RAM_STATS_EN
  word_t rd0, wr0, rd2, wr2, rd3, wr3;
`endif

  ram_model #(.LAT(0), .WORDS(1024)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0)
`ifdef RAM_STATS_EN
    , .rdcount(rd0), .wrcount(wr0)
`endif
  );

  ram_model #(.LAT(2), .WORDS(1024)) dut2 (
    .CLK(CLK), .RST(RST), .bus(bus2)
`ifdef RAM_STATS_EN
    , .rdcount(rd2), .wrcount(wr2)
`endif
  );

  ram_model #(.LAT(3), .WORDS(1024)) dut3 (
    .CLK(CLK), .RST(RST), .bus(bus3)
`ifdef RAM_STATS_EN
    , .rdcount(rd3), .wrcount(wr3)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int id, input logic ren, input logic wen,
                       input word_t a, input word_t d);
    case (id)
      0: begin bus0.ramREN = ren; bus0.ramWEN = wen; bus0.ramaddr = a; bus0.ramstore = d; end
      2: begin bus2.ramREN = ren; bus2.ramWEN = wen; bus2.ramaddr = a; bus2.ramstore = d; end
      default: begin bus3.ramREN = ren; bus3.ramWEN = wen; bus3.ramaddr = a; bus3.ramstore = d; end
    endcase
  endtask

  function automatic ramstate_t stateOf(input int id);
    case (id)
      0:       return bus0.ramstate;
      2:       return bus2.ramstate;
      default: return bus3.ramstate;
    endcase
  endfunction

  function automatic word_t loadOf(input int id);
    case (id)
      0:       return bus0.ramload;
      2:       return bus2.ramload;
      default: return bus3.ramload;
    endcase
  endfunction

  task automatic waitState(input int id, input ramstate_t st, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (stateOf(id) == st) break;
      tick();
    end
  endtask

  // Write a word through the normal handshake so later reads have known data
  task automatic preload(input int id, input word_t a, input word_t d);
    drive(id, 1'b0, 1'b1, a, d);
    waitState(id, ACCESS, 40);
    tick();
    drive(id, 1'b0, 1'b0, '0, '0);
    waitState(id, FREE, 40);
    nCompared++;
    if (stateOf(id) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL preload_timeout id%0d: state %0d expected %0d", id, stateOf(id), FREE);
    end
  endtask

  task automatic test_reset();
    int ids [3];
    ids = '{0, 2, 3};
    RST = 1'b1;
    foreach (ids[i]) drive(ids[i], 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    RST = 1'b0;
    foreach (ids[i]) begin
      nCompared++;
      if (stateOf(ids[i]) !== FREE) begin
        nMismatched++;
        $display("[TB] FAIL reset_state id%0d: got %0d expected %0d", ids[i], stateOf(ids[i]), FREE);
      end
      nCompared++;
      if (loadOf(ids[i]) !== 32'h0) begin
        nMismatched++;
        $display("[TB] FAIL reset_load id%0d: got %h expected 0", ids[i], loadOf(ids[i]));
      end
    end
  endtask

  task automatic test_write_read();
    ramstate_t seq [4];
    word_t     exp;
    seq = '{FREE, BUSY, BUSY, ACCESS};
    drive(2, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      nCompared++;
      if (stateOf(2) !== seq[i]) begin
        nMismatched++;
        $display("[TB] FAIL wr_seq[%0d]: got %0d expected %0d", i, stateOf(2), seq[i]);
      end
    end
    tick();
    nCompared++;
    if (stateOf(2) !== BUSY) begin
      nMismatched++;
      $display("[TB] FAIL wr_rearm: got %0d expected %0d", stateOf(2), BUSY);
    end
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    nCompared++;
    if (stateOf(2) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL wr_drop: got %0d expected %0d", stateOf(2), FREE);
    end
    drive(2, 1'b1, 1'b0, 32'h40, '0);
    expQ.push_back(32'hDEADBEEF);
    for (int i = 1; i < 4; i++) begin
      tick();
      nCompared++;
      if (stateOf(2) !== seq[i]) begin
        nMismatched++;
        $display("[TB] FAIL rd_seq[%0d]: got %0d expected %0d", i, stateOf(2), seq[i]);
      end
      exp = (seq[i] == ACCESS) ? expQ.pop_front() : 32'h0;
      nCompared++;
      if (loadOf(2) !== exp) begin
        nMismatched++;
        $display("[TB] FAIL rd_load[%0d]: got %h expected %h", i, loadOf(2), exp);
      end
    end
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    nCompared++;
    if (stateOf(2) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL rd_done: got %0d expected %0d", stateOf(2), FREE);
    end
  endtask

  task automatic test_back_to_back();
    word_t vals [3];
    word_t exp;
    vals = '{32'h11110000, 32'h22220004, 32'h33330008};
    for (int i = 0; i < 3; i++) preload(0, word_t'(i * 4), vals[i]);
    drive(0, 1'b1, 1'b0, 32'h0, '0);
    expQ.push_back(vals[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++;
      if (stateOf(0) !== ACCESS) begin
        nMismatched++;
        $display("[TB] FAIL b2b_state[%0d]: got %0d expected %0d", i, stateOf(0), ACCESS);
      end
      exp = expQ.pop_front();
      nCompared++;
      if (loadOf(0) !== exp) begin
        nMismatched++;
        $display("[TB] FAIL b2b_load[%0d]: got %h expected %h", i, loadOf(0), exp);
      end
      if (i < 2) begin
        drive(0, 1'b1, 1'b0, word_t'((i + 1) * 4), '0);
        expQ.push_back(vals[i + 1]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    nCompared++;
    if (stateOf(0) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL b2b_done: got %0d expected %0d", stateOf(0), FREE);
    end
  endtask

  task automatic test_error();
    word_t exp;
    preload(2, 32'h10, 32'hCAFEF00D);
    drive(2, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared++;
      if (stateOf(2) !== ERROR) begin
        nMismatched++;
        $display("[TB] FAIL both_state[%0d]: got %0d expected %0d", i, stateOf(2), ERROR);
      end
      nCompared++;
      if (loadOf(2) !== 32'h0) begin
        nMismatched++;
        $display("[TB] FAIL both_load[%0d]: got %h expected 0", i, loadOf(2));
      end
    end
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    nCompared++;
    if (stateOf(2) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL both_release: got %0d expected %0d", stateOf(2), FREE);
    end
    drive(2, 1'b1, 1'b0, 32'h10, '0);
    expQ.push_back(32'hCAFEF00D);
    waitState(2, ACCESS, 10);
    nCompared++;
    if (stateOf(2) !== ACCESS) begin
      nMismatched++;
      $display("[TB] FAIL both_readback_state: got %0d expected %0d", stateOf(2), ACCESS);
    end
    exp = expQ.pop_front();
    nCompared++;
    if (loadOf(2) !== exp) begin
      nMismatched++;
      $display("[TB] FAIL both_mem4: got %h expected %h", loadOf(2), exp);
    end
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_bad_address();
    word_t bad [2];
    bad = '{32'h42, 32'h1000};
    for (int i = 0; i < 2; i++) begin
      drive(2, 1'b1, 1'b0, bad[i], '0);
      tick();
      nCompared++;
      if (stateOf(2) !== ERROR) begin
        nMismatched++;
        $display("[TB] FAIL badaddr_state[%0d]: got %0d expected %0d", i, stateOf(2), ERROR);
      end
      nCompared++;
      if (loadOf(2) !== 32'h0) begin
        nMismatched++;
        $display("[TB] FAIL badaddr_load[%0d]: got %h expected 0", i, loadOf(2));
      end
      drive(2, 1'b0, 1'b0, '0, '0);
      tick();
      nCompared++;
      if (stateOf(2) !== FREE) begin
        nMismatched++;
        $display("[TB] FAIL badaddr_release[%0d]: got %0d expected %0d", i, stateOf(2), FREE);
      end
    end
  endtask

  task automatic test_restart();
    ramstate_t want;
    word_t     exp;
    preload(3, 32'h20, 32'hA0000008);
    preload(3, 32'h24, 32'h90000009);
    drive(3, 1'b1, 1'b0, 32'h20, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared++;
      if (stateOf(3) !== BUSY) begin
        nMismatched++;
        $display("[TB] FAIL restart_pre[%0d]: got %0d expected %0d", i, stateOf(3), BUSY);
      end
    end
    drive(3, 1'b1, 1'b0, 32'h24, '0);
    expQ.push_back(32'h90000009);
    for (int i = 1; i <= 4; i++) begin
      tick();
      want = (i < 4) ? BUSY : ACCESS;
      nCompared++;
      if (stateOf(3) !== want) begin
        nMismatched++;
        $display("[TB] FAIL restart_seq[%0d]: got %0d expected %0d", i, stateOf(3), want);
      end
    end
    exp = expQ.pop_front();
    nCompared++;
    if (loadOf(3) !== exp) begin
      nMismatched++;
      $display("[TB] FAIL restart_load: got %h expected %h", loadOf(3), exp);
    end
    drive(3, 1'b0, 1'b0, '0, '0);
    tick();
    nCompared++;
    if (stateOf(3) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL restart_done: got %0d expected %0d", stateOf(3), FREE);
    end
  endtask

  task automatic test_reset_write();
    word_t exp;
    preload(2, 32'h8, 32'h0BADF00D);
    drive(2, 1'b0, 1'b1, 32'h8, 32'h12345678);
    tick();
    nCompared++;
    if (stateOf(2) !== BUSY) begin
      nMismatched++;
      $display("[TB] FAIL rstwr_busy: got %0d expected %0d", stateOf(2), BUSY);
    end
    RST = 1'b1;
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    RST = 1'b0;
    nCompared++;
    if (stateOf(2) !== FREE) begin
      nMismatched++;
      $display("[TB] FAIL rstwr_free: got %0d expected %0d", stateOf(2), FREE);
    end
`ifdef RAM_STATS_EN
    nCompared++;
    if (wr2 !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL rstwr_wrcount: got %0d expected 0", wr2);
    end
    nCompared++;
    if (rd2 !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL rstwr_rdcount: got %0d expected 0", rd2);
    end
`endif
    drive(2, 1'b1, 1'b0, 32'h8, '0);
    expQ.push_back(32'h0BADF00D);
    waitState(2, ACCESS, 10);
    nCompared++;
    if (stateOf(2) !== ACCESS) begin
      nMismatched++;
      $display("[TB] FAIL rstwr_read_state: got %0d expected %0d", stateOf(2), ACCESS);
    end
    exp = expQ.pop_front();
    nCompared++;
    if (loadOf(2) !== exp) begin
      nMismatched++;
      $display("[TB] FAIL rstwr_mem2: got %h expected %h", loadOf(2), exp);
    end
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    drive(3, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_error();
    test_bad_address();
    test_restart();
    test_reset_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ram_model.md
RAM_MODEL -- requirements
Module: ram_model

Interface
REQ-001 SHALL have parameter LAT, default 2: wait-state count before ACCESS; legal range 0..15.
REQ-002 SHALL have parameter WORDS, default 1024: number of 32-bit words; power of two.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port ramREN  input  1  read request, level, held until ACCESS.
REQ-006 SHALL have port ramWEN  input  1  write request, level, held until ACCESS.
REQ-007 SHALL have port ramaddr  input  32  byte address (word_t).
REQ-008 SHALL have port ramstore  input  32  write data.
REQ-009 SHALL have port ramload  output  32  read data, valid only while ramstate==ACCESS on a read.
REQ-010 SHALL have port ramstate  output  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-011 SHALL implement a registered FSM whose state drives ramstate directly.
REQ-012 SHALL define a request as valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0, and ramaddr[31:2] < WORDS.
REQ-013 SHALL, in FREE with no request, stay FREE; with a valid request, go to BUSY with counter=LAT, or to ACCESS if LAT==0.
REQ-014 SHALL, in BUSY, decrement the counter each cycle and go to ACCESS on the edge where counter==1.
REQ-015 SHALL latch {REN, WEN, addr, store} on entry to BUSY/ACCESS; any change in BUSY restarts the count at LAT; a dropped request returns to FREE.
REQ-016 SHALL hold ACCESS exactly one cycle; ACCESS therefore appears LAT+1 cycles after a request is first seen.
REQ-017 SHALL, in ACCESS on a read, drive ramload = mem[addr[WORDS_W+1:2]] combinationally; ramload SHALL be 0 in all other states.
REQ-018 SHALL, in ACCESS on a write, commit ramstore to mem on the closing edge only if ramWEN is still high and the request is unchanged.
REQ-019 SHALL, after ACCESS, re-evaluate as from FREE: a request still present starts a new access (BUSY, or ACCESS if LAT==0), giving back-to-back service.
REQ-020 SHALL enter ERROR from any state when ramREN and ramWEN are both high, or the address is misaligned or out of range while either is high; no memory write in ERROR.
REQ-021 SHALL hold ERROR for at least one cycle, then re-evaluate as from FREE.
REQ-022 SHALL leave memory contents unchanged by reads, errors and aborted writes.

Reset
REQ-023 SHALL, on RST high at a clock edge, set state FREE, counter 0, latched request 0, ramload 0; an in-flight write is discarded.
REQ-024 SHALL NOT clear memory contents on reset.

Configuration
REQ-025 SHALL compile in access statistics when RAM_STATS_EN is defined: outputs rdcount and wrcount (32 bits each) count completed read and committed write ACCESS cycles, cleared by RST, and wrap at 2^32.
REQ-026 SHALL, without RAM_STATS_EN, have no rdcount or wrcount ports and no counter logic.

Structure
REQ-027 SHALL take ramstate_t, word_t and WORD_W from cpu_types_pkg; no new package types.
REQ-028 SHALL derive WORDS_W = $clog2(WORDS) as a local parameter.
REQ-029 SHALL be a single module with no sub-modules; the memory array is inline.

Verification
REQ-030 LAT=2: write 0xDEADBEEF to 0x40 -> FREE, BUSY, BUSY, ACCESS; then read 0x40 -> ACCESS on the 3rd cycle with ramload=0xDEADBEEF.
REQ-031 LAT=0: reads of 0x0, 0x4, 0x8 held back-to-back -> ACCESS every cycle; ramload = stored words in order.
REQ-032 REN and WEN both high at 0x10 -> ERROR while held; mem[4] unchanged; FREE once both drop.
REQ-033 Read of 0x42 (misaligned), then read of 0x1000 with WORDS=1024 -> ERROR each time; ramload=0.
REQ-034 LAT=3: address changes 0x20->0x24 in the 2nd BUSY cycle -> count restarts; ACCESS 4 cycles after the change; ramload=mem[9].
REQ-035 RST pulsed during BUSY of a write of 0x12345678 to 0x8 -> FREE next cycle; mem[2] keeps its old value; with RAM_STATS_EN, wrcount=0.
